// File: rtl/mem_copy_engine.sv
// ---------------------------------------------------------------------------
// mem_copy_engine
//
// Purpose:
//   Byte-block copy engine that sits directly in front of a single-port data
//   memory. When idle, CPU load/store traffic passes straight through to the
//   memory. When a copy is requested, the engine takes the memory for one read
//   cycle and one write cycle per byte, and it stalls the CPU until the copy
//   completes.
//
// Optional feature (macro MEM_COPY_CHECKSUM_EN):
//   When the macro is defined, a modulo-2^DATA_W sum of every byte read during
//   a copy is kept and driven on 'checksum'. When it is undefined, 'checksum'
//   is tied to zero.
//
// Ports:
//   CLK, reset            clock, asynchronous active-high reset
//   start                 copy request, sampled only in IDLE
//   src_addr, dst_addr    first source and destination addresses
//   length                byte count (0 = no-op that still pulses done)
//   busy, done            busy in RD/WR/DONE; done is a one-cycle pulse in DONE
//   cpu_*                 CPU memory request and response
//   cpu_stall             high while the engine owns the memory (RD/WR)
//   Data_*                memory-side address, enables and data
//   checksum              sum of the copied bytes, or 0 when the feature is off
//   o_dbg_state           current FSM state, for observation
//
// Handshake: the CPU issues a request by holding cpu_read_en or cpu_write_en
// with the address and data stable. The request completes on the first rising
// edge where cpu_stall is low. A copy is accepted on the edge where start is
// high and the engine is in IDLE (busy low). A start that arrives while busy
// is high is dropped; it is not queued.
// ---------------------------------------------------------------------------
module mem_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_read_en,
  input  logic              cpu_write_en,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic [ADDR_W-1:0] Data_address,
  output logic              Data_read_en,
  output logic              Data_write_en,
  output logic [DATA_W-1:0] Data_memory_in,
  input  logic [DATA_W-1:0] Data_memory_out,
  output logic [DATA_W-1:0] checksum,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W-1:0] r_count;
  logic [DATA_W-1:0] r_buf;
  logic              w_accept;

  // A request is taken only in IDLE; elsewhere start is ignored.
  assign w_accept = (r_state == ST_IDLE) && start;

  // State register
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          // A zero-length request skips the memory and only pulses done.
          w_next_state = (length != '0) ? ST_RD : ST_DONE;
        end
      end
      ST_RD:   w_next_state = ST_WR;
      ST_WR:   w_next_state = (r_count == ADDR_W'(1)) ? ST_DONE : ST_RD;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Copy datapath: pointers, remaining count and the one-byte buffer.
  // Addresses increment modulo 2^ADDR_W by natural width overflow.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_buf   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (length != '0)) begin
            r_src   <= src_addr;
            r_dst   <= dst_addr;
            r_count <= length;
          end
        end
        ST_RD: begin
          r_buf <= Data_memory_out;
        end
        ST_WR: begin
          r_src   <= r_src + ADDR_W'(1);
          r_dst   <= r_dst + ADDR_W'(1);
          r_count <= r_count - ADDR_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Memory bus mux and status outputs. Outside RD/WR the CPU drives the
  // memory combinationally, which includes the DONE cycle.
  always_comb begin
    Data_address   = cpu_address;
    Data_read_en   = cpu_read_en;
    Data_write_en  = cpu_write_en;
    Data_memory_in = cpu_wdata;
    busy           = 1'b0;
    done           = 1'b0;
    cpu_stall      = 1'b0;
    case (r_state)
      ST_RD: begin
        Data_address   = r_src;
        Data_read_en   = 1'b1;
        Data_write_en  = 1'b0;
        Data_memory_in = r_buf;
        busy           = 1'b1;
        cpu_stall      = 1'b1;
      end
      ST_WR: begin
        Data_address   = r_dst;
        Data_read_en   = 1'b0;
        Data_write_en  = 1'b1;
        Data_memory_in = r_buf;
        busy           = 1'b1;
        cpu_stall      = 1'b1;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign cpu_rdata   = Data_memory_out;
  assign o_dbg_state = r_state;

`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // The sum restarts on every accepted request, including zero-length ones.
  // It accumulates on each read cycle and then holds until the next request.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= '0;
    end else if (r_state == ST_RD) begin
      r_checksum <= r_checksum + Data_memory_out;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule
